// File: rtl/synth_pkg.sv
// Shared definitions for the FM synthesizer voice path: default field widths,
// allocator state encoding and the age counter width helper.
package synth_pkg;

  localparam int NOTE_BITS_DEF = 7;
  localparam int VEL_BITS_DEF  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_APPLY = 2'd2,
    ST_KILL  = 2'd3
  } state_e;

  // One spare bit above the voice-index width so a full rotation of
  // allocations is still distinguishable before saturation.
  function automatic int age_width(input int num_voices);
    return $clog2(num_voices) + 1;
  endfunction

endpackage

// File: rtl/voice_age_tracker.sv
// Per-voice saturating age counters and the oldest-active-voice search used
// by the allocator when it has to steal a voice.
module voice_age_tracker #(
  parameter int NUM_VOICES = 8,
  parameter int AGE_BITS   = 4,
  parameter int IDX_BITS   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  age_clr,
  input  logic [IDX_BITS-1:0]   age_clr_idx,
  input  logic                  age_bump,
  input  logic [NUM_VOICES-1:0] active_mask,
  output logic [IDX_BITS-1:0]   oldest_idx,
  output logic                  oldest_valid
);

  logic [AGE_BITS-1:0] age_q [NUM_VOICES];
  logic [AGE_BITS-1:0] age_d [NUM_VOICES];
  logic [AGE_BITS-1:0] best_age;

  // The cleared voice is excluded from the bump: it is the one being newly gated.
  generate
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_age
      always_comb begin
        age_d[gi] = age_q[gi];
        if (age_clr && (age_clr_idx == IDX_BITS'(gi))) begin
          age_d[gi] = '0;
        end else if (age_bump && active_mask[gi] && (age_q[gi] != '1)) begin
          age_d[gi] = age_q[gi] + AGE_BITS'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          age_q[gi] <= '0;
        end else begin
          age_q[gi] <= age_d[gi];
        end
      end
    end
  endgenerate

  // Strict greater-than keeps the lowest index on equal ages.
  always_comb begin
    oldest_idx   = '0;
    oldest_valid = 1'b0;
    best_age     = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (active_mask[i] && (!oldest_valid || (age_q[i] > best_age))) begin
        oldest_idx   = IDX_BITS'(i);
        oldest_valid = 1'b1;
        best_age     = age_q[i];
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: accepts note events, scans voices one per cycle
// and gates/retriggers/releases them. Voice stealing is built with VOICE_STEAL_EN.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int NOTE_BITS  = NOTE_BITS_DEF,
  parameter int VEL_BITS   = VEL_BITS_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             evt_valid,
  output logic                             evt_ready,
  input  logic                             evt_on,
  input  logic [NOTE_BITS-1:0]             evt_note,
  input  logic [VEL_BITS-1:0]              evt_velocity,
  input  logic [NUM_VOICES-1:0]            voice_available,
  output logic [NUM_VOICES-1:0]            note_en,
  output logic [NUM_VOICES*NOTE_BITS-1:0]  voice_note,
  output logic [NUM_VOICES*VEL_BITS-1:0]   voice_velocity,
  output logic                             steal,
  output logic                             drop
);

  localparam int IDX_BITS = $clog2(NUM_VOICES);

  state_e                          state_q, state_d;
  logic [IDX_BITS-1:0]             idx_q, idx_d;
  logic                            lat_on_q, lat_on_d;
  logic [NOTE_BITS-1:0]            lat_note_q, lat_note_d;
  logic [VEL_BITS-1:0]             lat_vel_q, lat_vel_d;
  logic                            match_hit_q, match_hit_d;
  logic [IDX_BITS-1:0]             match_idx_q, match_idx_d;
  logic                            free_hit_q, free_hit_d;
  logic [IDX_BITS-1:0]             free_idx_q, free_idx_d;
  logic [NUM_VOICES-1:0]           note_en_q, note_en_d;
  logic [NUM_VOICES*NOTE_BITS-1:0] voice_note_q, voice_note_d;
  logic [NUM_VOICES*VEL_BITS-1:0]  voice_vel_q, voice_vel_d;
  logic                            drop_q, drop_d;

`ifdef VOICE_STEAL_EN
  localparam int AGE_BITS = age_width(NUM_VOICES);

  logic                            steal_q, steal_d;
  logic [IDX_BITS-1:0]             victim_q, victim_d;
  logic                            age_clr;
  logic [IDX_BITS-1:0]             age_clr_idx;
  logic                            age_bump;
  logic [IDX_BITS-1:0]             oldest_idx;
  logic                            oldest_valid;

  voice_age_tracker #(
    .NUM_VOICES (NUM_VOICES),
    .AGE_BITS   (AGE_BITS),
    .IDX_BITS   (IDX_BITS)
  ) u_age (
    .clk          (clk),
    .rst          (rst),
    .age_clr      (age_clr),
    .age_clr_idx  (age_clr_idx),
    .age_bump     (age_bump),
    .active_mask  (note_en_q),
    .oldest_idx   (oldest_idx),
    .oldest_valid (oldest_valid)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (evt_valid && evt_ready) begin
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (idx_q == IDX_BITS'(NUM_VOICES - 1)) begin
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        state_d = ST_IDLE;
`ifdef VOICE_STEAL_EN
        if (lat_on_q && !match_hit_q && !free_hit_q) begin
          state_d = ST_KILL;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready is withheld during reset so an event cannot be taken on a reset edge.
  always_comb begin
    evt_ready = (state_q == ST_IDLE) && !rst;
  end

  always_comb begin
    idx_d        = idx_q;
    lat_on_d     = lat_on_q;
    lat_note_d   = lat_note_q;
    lat_vel_d    = lat_vel_q;
    match_hit_d  = match_hit_q;
    match_idx_d  = match_idx_q;
    free_hit_d   = free_hit_q;
    free_idx_d   = free_idx_q;
    note_en_d    = note_en_q;
    voice_note_d = voice_note_q;
    voice_vel_d  = voice_vel_q;
    drop_d       = 1'b0;
`ifdef VOICE_STEAL_EN
    steal_d      = 1'b0;
    victim_d     = victim_q;
    age_clr      = 1'b0;
    age_clr_idx  = '0;
    age_bump     = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (evt_valid && evt_ready) begin
          lat_on_d    = evt_on;
          lat_note_d  = evt_note;
          lat_vel_d   = evt_velocity;
          idx_d       = '0;
          match_hit_d = 1'b0;
          match_idx_d = '0;
          free_hit_d  = 1'b0;
          free_idx_d  = '0;
        end
      end

      ST_SCAN: begin
        if (!match_hit_q && note_en_q[idx_q] &&
            (voice_note_q[idx_q*NOTE_BITS +: NOTE_BITS] == lat_note_q)) begin
          match_hit_d = 1'b1;
          match_idx_d = idx_q;
        end
        if (!free_hit_q && !note_en_q[idx_q] && voice_available[idx_q]) begin
          free_hit_d = 1'b1;
          free_idx_d = idx_q;
        end
        idx_d = idx_q + IDX_BITS'(1);
      end

      ST_APPLY: begin
        if (!lat_on_q) begin
          // Release keeps note and velocity so the tail holds its pitch.
          if (match_hit_q) begin
            note_en_d[match_idx_q] = 1'b0;
          end
        end else if (match_hit_q) begin
          voice_vel_d[match_idx_q*VEL_BITS +: VEL_BITS] = lat_vel_q;
`ifdef VOICE_STEAL_EN
          age_clr     = 1'b1;
          age_clr_idx = match_idx_q;
`endif
        end else if (free_hit_q) begin
          voice_note_d[free_idx_q*NOTE_BITS +: NOTE_BITS] = lat_note_q;
          voice_vel_d[free_idx_q*VEL_BITS +: VEL_BITS]    = lat_vel_q;
          note_en_d[free_idx_q]                           = 1'b1;
`ifdef VOICE_STEAL_EN
          age_clr     = 1'b1;
          age_clr_idx = free_idx_q;
          age_bump    = 1'b1;
`endif
        end else begin
`ifdef VOICE_STEAL_EN
          // Gate is dropped now and raised in KILL, forcing an attack restart.
          victim_d = oldest_valid ? oldest_idx : '0;
          note_en_d[victim_d]                           = 1'b0;
          voice_note_d[victim_d*NOTE_BITS +: NOTE_BITS] = lat_note_q;
          voice_vel_d[victim_d*VEL_BITS +: VEL_BITS]    = lat_vel_q;
          steal_d                                       = 1'b1;
`else
          drop_d = 1'b1;
`endif
        end
      end

`ifdef VOICE_STEAL_EN
      ST_KILL: begin
        note_en_d[victim_q] = 1'b1;
        age_clr             = 1'b1;
        age_clr_idx         = victim_q;
        age_bump            = 1'b1;
      end
`endif

      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= '0;
      lat_on_q     <= 1'b0;
      lat_note_q   <= '0;
      lat_vel_q    <= '0;
      match_hit_q  <= 1'b0;
      match_idx_q  <= '0;
      free_hit_q   <= 1'b0;
      free_idx_q   <= '0;
      note_en_q    <= '0;
      voice_note_q <= '0;
      voice_vel_q  <= '0;
      drop_q       <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      lat_on_q     <= lat_on_d;
      lat_note_q   <= lat_note_d;
      lat_vel_q    <= lat_vel_d;
      match_hit_q  <= match_hit_d;
      match_idx_q  <= match_idx_d;
      free_hit_q   <= free_hit_d;
      free_idx_q   <= free_idx_d;
      note_en_q    <= note_en_d;
      voice_note_q <= voice_note_d;
      voice_vel_q  <= voice_vel_d;
      drop_q       <= drop_d;
    end
  end

`ifdef VOICE_STEAL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      steal_q  <= 1'b0;
      victim_q <= '0;
    end else begin
      steal_q  <= steal_d;
      victim_q <= victim_d;
    end
  end

  assign steal = steal_q;
`else
  assign steal = 1'b0;
`endif

  assign note_en        = note_en_q;
  assign voice_note     = voice_note_q;
  assign voice_velocity = voice_vel_q;
  assign drop           = drop_q;

endmodule
